// File: rtl/rf_write_port_arbiter.sv
// rf_write_port_arbiter: shares the register-file write port between the WB stage (priority)
// and a FIFO of MDU results. A wait counter forces a one-cycle drain that stalls WB.
`default_nettype none

module rf_write_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int REG_NUM    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8,
  localparam int AW        = $clog2(REG_NUM),
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             mdu_valid,
  input  logic [AW-1:0]    mdu_addr,
  input  logic [WIDTH-1:0] mdu_data,
  output logic             mdu_ready,
  output logic             wb_stall,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [WIDTH-1:0] rf_wd,
  output logic [CW-1:0]    fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    addr_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_nxt;
  logic             full;
  logic             empty;
  logic             wb_req;
  logic             push;
  logic             pop;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign wb_req     = wb_we && (wb_addr != '0);
  assign fifo_count = count;

  // Outputs are forced to their reset values while RST is held low, without waiting for a clock.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    mdu_ready = 1'b0;
    wb_stall  = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wd     = '0;
    push      = 1'b0;
    pop       = 1'b0;
    if (RST) begin
      mdu_ready = !full;
      // Results to r0 are acknowledged but never occupy a slot.
      push      = mdu_valid && !full && (mdu_addr != '0);
      case (state)
        DRAIN: begin
          wb_stall  = 1'b1;
          pop       = !empty;
          wait_nxt  = '0;
          state_nxt = NORMAL;
        end
        default: begin
          if (wb_req) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wd    = wb_data;
          end else begin
            pop = !empty;
          end
          if (pop || empty) begin
            wait_nxt = '0;
          end else begin
            wait_nxt = wait_cnt + WW'(1);
            if (wait_nxt == WW'(MAX_WAIT)) begin
              state_nxt = DRAIN;
            end
          end
        end
      endcase
      if (pop) begin
        rf_we    = 1'b1;
        rf_waddr = addr_mem[rd_ptr];
        rf_wd    = data_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= NORMAL;
      wait_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr] <= mdu_addr;
      data_mem[wr_ptr] <= mdu_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_write_port_arbiter.sv
// Testbench for rf_write_port_arbiter: directed vector table, hand sequences for drain/full/reset,
// and randomized traffic checked against a queue-based reference model.
`default_nettype none

module tb_rf_write_port_arbiter;

  localparam int WIDTH      = 32;
  localparam int REG_NUM    = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_WAIT   = 8;
  localparam int AW         = 5;
  localparam int CW         = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             wb_we = 1'b0;
  logic [AW-1:0]    wb_addr = '0;
  logic [WIDTH-1:0] wb_data = '0;
  logic             mdu_valid = 1'b0;
  logic [AW-1:0]    mdu_addr = '0;
  logic [WIDTH-1:0] mdu_data = '0;
  logic             mdu_ready;
  logic             wb_stall;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wd;
  logic [CW-1:0]    fifo_count;

  rf_write_port_arbiter #(
    .WIDTH(WIDTH), .REG_NUM(REG_NUM), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wd(rf_wd),
    .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: buffered results in arrival order, ungranted-cycle count, pending forced drain.
  typedef struct packed {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } ent_t;
  ent_t q[$];
  int   m_wait  = 0;
  bit   m_drain = 0;

  // DUT outputs sampled by the last cycle() call.
  logic             s_we, s_stall, s_ready;
  logic [AW-1:0]    s_addr;
  logic [WIDTH-1:0] s_data;
  logic [CW-1:0]    s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_wait  = 0;
    m_drain = 0;
  endfunction

  // One clock cycle: drive, compare against the model at negedge, advance the model at posedge.
  task automatic cycle(input logic wwe, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic mv, input logic [AW-1:0] ma, input logic [WIDTH-1:0] md);
    int               n;
    bit               e_full, e_pop, e_wb;
    logic             e_we;
    logic [AW-1:0]    e_addr;
    logic [WIDTH-1:0] e_data;
    wb_we = wwe; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    @(negedge CLK);
    n      = q.size();
    e_full = (n == FIFO_DEPTH);
    e_wb   = !m_drain && wwe && (wa != 0);
    e_pop  = !e_wb && (n > 0);
    e_we   = e_wb || e_pop;
    e_addr = e_pop ? q[0].a : (e_wb ? wa : '0);
    e_data = e_pop ? q[0].d : (e_wb ? wd : '0);
    s_we = rf_we; s_addr = rf_waddr; s_data = rf_wd;
    s_stall = wb_stall; s_ready = mdu_ready; s_cnt = fifo_count;
    chk("model rf_we", 32'(rf_we), 32'(e_we));
    chk("model rf_waddr", 32'(rf_waddr), 32'(e_addr));
    chk("model rf_wd", rf_wd, e_data);
    chk("model wb_stall", 32'(wb_stall), 32'(m_drain));
    chk("model mdu_ready", 32'(mdu_ready), 32'(!e_full));
    chk("model fifo_count", 32'(fifo_count), 32'(n));
    @(posedge CLK);
    if (e_pop) void'(q.pop_front());
    if (mv && !e_full && ma != 0) q.push_back('{a: ma, d: md});
    if (m_drain) begin
      m_wait = 0; m_drain = 0;
    end else if (e_pop || n == 0) begin
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait == MAX_WAIT) m_drain = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h1; mdu_valid = 1'b1; mdu_addr = 5'd4;
    @(negedge CLK);
    chk("reset rf_we", 32'(rf_we), 0);
    chk("reset mdu_ready", 32'(mdu_ready), 0);
    chk("reset wb_stall", 32'(wb_stall), 0);
    chk("reset fifo_count", 32'(fifo_count), 0);
    chk("reset rf_waddr", 32'(rf_waddr), 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    model_reset();
    wb_we = 1'b0; mdu_valid = 1'b0;
  endtask

  typedef struct {
    logic             wwe;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             mv;
    logic [AW-1:0]    ma;
    logic [WIDTH-1:0] md;
    logic             x_we;
    logic [AW-1:0]    x_addr;
    logic [WIDTH-1:0] x_data;
    logic             x_ready;
    logic [CW-1:0]    x_cnt;
  } vec_t;

  vec_t             tbl[12];
  logic             h_wwe, h_mv, h_acc;
  logic [AW-1:0]    h_wa, h_ma;
  logic [WIDTH-1:0] h_wd, h_md;

  initial begin
    tbl[0]  = '{1, 5'd5, 32'hAAAA5555, 0, 5'd0, 32'h0,  1, 5'd5, 32'hAAAA5555, 1, 3'd0};
    tbl[1]  = '{0, 5'd0, 32'h0,        1, 5'd7, 32'h12, 0, 5'd0, 32'h0,        1, 3'd0};
    tbl[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd7, 32'h12,       1, 3'd1};
    tbl[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 32'h0,        1, 3'd0};
    tbl[4]  = '{1, 5'd3, 32'h33,       1, 5'd9, 32'h99, 1, 5'd3, 32'h33,       1, 3'd0};
    tbl[5]  = '{1, 5'd0, 32'hFF,       1, 5'd0, 32'h55, 1, 5'd9, 32'h99,       1, 3'd1};
    tbl[6]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 32'h0,        1, 3'd0};
    tbl[7]  = '{1, 5'd4, 32'h44,       1, 5'd9, 32'h9,  1, 5'd4, 32'h44,       1, 3'd0};
    tbl[8]  = '{1, 5'd4, 32'h45,       1, 5'd0, 32'h77, 1, 5'd4, 32'h45,       1, 3'd1};
    tbl[9]  = '{1, 5'd4, 32'h46,       0, 5'd0, 32'h0,  1, 5'd4, 32'h46,       1, 3'd1};
    tbl[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd9, 32'h9,        1, 3'd1};
    tbl[11] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 32'h0,        1, 3'd0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].wwe, tbl[i].wa, tbl[i].wd, tbl[i].mv, tbl[i].ma, tbl[i].md);
      chk($sformatf("vec%0d rf_we", i), 32'(s_we), 32'(tbl[i].x_we));
      chk($sformatf("vec%0d rf_waddr", i), 32'(s_addr), 32'(tbl[i].x_addr));
      chk($sformatf("vec%0d rf_wd", i), s_data, tbl[i].x_data);
      chk($sformatf("vec%0d mdu_ready", i), 32'(s_ready), 32'(tbl[i].x_ready));
      chk($sformatf("vec%0d fifo_count", i), 32'(s_cnt), 32'(tbl[i].x_cnt));
    end

    // Starvation: WB busy every cycle, one MDU result forced out after MAX_WAIT ungranted cycles.
    do_reset();
    cycle(1, 5'd1, 32'h100, 1, 5'd11, 32'hBEEF);
    for (int k = 1; k <= MAX_WAIT; k++) begin
      cycle(1, 5'd1, 32'h100 + k, 0, 5'd0, 32'h0);
      chk("starve no stall", 32'(s_stall), 0);
      chk("starve wb addr", 32'(s_addr), 1);
    end
    cycle(1, 5'd1, 32'h200, 0, 5'd0, 32'h0);
    chk("drain stall", 32'(s_stall), 1);
    chk("drain addr", 32'(s_addr), 11);
    chk("drain data", s_data, 32'hBEEF);
    cycle(1, 5'd1, 32'h201, 0, 5'd0, 32'h0);
    chk("post drain stall", 32'(s_stall), 0);
    chk("post drain wb data", s_data, 32'h201);
    chk("post drain count", 32'(s_cnt), 0);

    // Full FIFO: a fifth result is held until the cycle after the forced pop.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1, 5'd2, 32'h0, 1, AW'(20 + k), 32'(k));
    for (int k = 4; k <= MAX_WAIT; k++) begin
      cycle(1, 5'd2, 32'h0, 1, 5'd24, 32'h24);
      chk("full count", 32'(s_cnt), 4);
      chk("full not ready", 32'(s_ready), 0);
    end
    cycle(1, 5'd2, 32'h0, 1, 5'd24, 32'h24);
    chk("full drain stall", 32'(s_stall), 1);
    chk("full drain head", 32'(s_addr), 20);
    chk("full drain not ready", 32'(s_ready), 0);
    cycle(1, 5'd2, 32'h0, 1, 5'd24, 32'h24);
    chk("after pop ready", 32'(s_ready), 1);
    chk("after pop count", 32'(s_cnt), 3);
    cycle(1, 5'd2, 32'h0, 0, 5'd0, 32'h0);
    chk("fifth accepted count", 32'(s_cnt), 4);

    // Asynchronous reset in the middle of a cycle with entries buffered.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, 5'd6, 32'h6, 1, AW'(10 + k), 32'(k));
    wb_we = 1'b1; wb_addr = 5'd6; mdu_valid = 1'b0;
    #1;
    chk("pre-reset count", 32'(fifo_count), 3);
    RST = 1'b0;
    #1;
    chk("async rst rf_we", 32'(rf_we), 0);
    chk("async rst count", 32'(fifo_count), 0);
    chk("async rst ready", 32'(mdu_ready), 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      chk("idle after reset rf_we", 32'(s_we), 0);
    end

    // Random traffic; the MDU keeps its offer stable until accepted.
    h_mv = 0; h_acc = 0; h_ma = '0; h_md = '0;
    for (int i = 0; i < 600; i++) begin
      h_wwe = (i < 300) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      h_wa  = AW'($urandom_range(0, 31));
      h_wd  = $urandom;
      if (!h_mv || h_acc) begin
        h_mv = ($urandom_range(0, 2) == 0);
        h_ma = AW'($urandom_range(0, 31));
        h_md = $urandom;
      end
      cycle(h_wwe, h_wa, h_wd, h_mv, h_ma, h_md);
      h_acc = h_mv && s_ready;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
